breath_led_ctrl: RTL and testbench
==================================

Name: breath_led_ctrl

Overview:
Mode sequencer for a bank of breathing LEDs. It owns the us/ms/s PWM timebase and decides, per mode, which LED channels receive the breathing PWM, which are held on and which are held off. A debounced key pulse steps through the modes. It sits between the key debounce block and the board LED pins.

Parameters:
CNT_1US_MAX, 6'd4, terminal count of the base tick counter (sim default; 49 on 50 MHz hardware)
CNT_1MS_MAX, 10'd9, terminal count of the PWM-slot counter (one PWM period = CNT_1MS_MAX+1 slots)
CNT_1S_MAX, 10'd9, terminal count of the duty-step counter (one ramp = CNT_1S_MAX+1 PWM periods)
LED_NUM, 4, number of LED channels (2..8)

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  reset; asynchronous assert, active low
key_flag  input  1  single-cycle pulse from debounce; advances mode
led_out  output  LED_NUM  LED drive, active low (0 = lit)
mode  output  2  current mode: 0 OFF, 1 BREATH_ALL, 2 CHASE, 3 ALL_ON
cycle_done  output  1  one-cycle pulse at end of each full up+down breath cycle

Behaviour:
- Reset values: led_out all 1s, mode=0 (OFF), cycle_done=0, all counters 0, dir=0, chase index=0.
- Timebase:
  - cnt_us counts 0..CNT_1US_MAX and wraps.
  - cnt_ms increments when cnt_us==max, and wraps at CNT_1MS_MAX.
  - cnt_s increments at cnt_ms wrap, and wraps at CNT_1S_MAX.
  - s_end = all three counters at max. dir toggles on s_end.
- Breath term: brt = (dir==0 && cnt_s>=cnt_ms) || (dir==1 && cnt_s<=cnt_ms). dir=0 is the brightening ramp; dir=1 is the dimming ramp.
- Mode FSM: OFF->BREATH_ALL->CHASE->ALL_ON->OFF, advancing on each key_flag.
- On key_flag:
  - The same edge clears cnt_us, cnt_ms, cnt_s, dir and the chase index.
  - key_flag takes priority over any coincident s_end, so no index advance and no cycle_done occur.
- Per-mode output (lit = 0):
  - OFF: all channels unlit.
  - ALL_ON: all channels lit.
  - BREATH_ALL: every channel lit iff brt.
  - CHASE: only channel idx is lit iff brt; all other channels unlit.
- Chase index advance: idx advances on s_end with dir==1 (end of the dimming ramp), wrapping LED_NUM-1 -> 0.
- cycle_done: pulses for 1 cycle, registered, on s_end with dir==1 in modes BREATH_ALL and CHASE only.
- Latency: led_out is registered, 1 cycle after the counter/mode state that produces it. mode is a registered FSM state, valid the cycle after key_flag.
- Timebase runs in every mode; it is ignored in OFF and ALL_ON.
- Asynchronous reset mid-operation returns everything to reset values immediately. There is no partial state.
- Counter widths are fixed (6/10/10 bits); parameters must fit those widths.

Decomposition:
- Shared package: mode encodings (MODE_OFF=2'd0, MODE_BREATH=2'd1, MODE_CHASE=2'd2, MODE_ON=2'd3) and the default CNT_* constants.
- Sub-module: breath_timebase (cnt_us/cnt_ms/cnt_s/dir).
  - Inputs: clk, rst_n, sync clear.
  - Outputs: brt, s_end, dir.
- The top level keeps the mode FSM, chase index and output mux.

Test Plan:
- Reset held, then released with no key: led_out=4'hF, mode=0, cycle_done=0 for 2000 clocks.
- One key_flag (mode=1):
  - Slot 0 of period 0 (clocks 1..5 after clear, +1 latency): led_out=4'h0.
  - Slots 1..9 of that period: led_out=4'hF.
  - Period 9 (cnt_s=9): led_out=4'h0 for all 50 clocks.
  - dir=1, cnt_s=9: led_out=4'h0 only in slot 9.
- Mode=1 steady: cycle_done pulses every 1000 clocks, exactly 1 cycle wide.
- Two key_flags (mode=2):
  - Only bit0 toggles during the first 1000 clocks; bit1 during the next 1000.
  - Bits 2, 3, then bit0 follow (wrap); non-selected bits remain 1.
- key_flag asserted on the same clock as s_end with dir=1 in CHASE: mode becomes 3, idx=0, no cycle_done, led_out=4'h0 next cycle. A further key gives mode=0, led_out=4'hF.
- sys_rst_n pulsed low mid-ramp in CHASE with idx=2: led_out=4'hF immediately, mode=0, idx=0. After release plus two key_flags, breathing restarts on channel 0 from cnt_s=0, dir=0.

Source files
------------

// File: rtl/breath_led_ctrl_pkg.sv
// Shared mode encodings and default timebase constants for the breathing LED sequencer.
package breath_led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_BREATH = 2'd1,
      MODE_CHASE  = 2'd2,
      MODE_ON     = 2'd3
   } mode_e;

   // Simulation-sized defaults; hardware at 50 MHz uses 49 for the base tick
   localparam logic [5:0] CNT_1US_MAX_DEF = 6'd4;
   localparam logic [9:0] CNT_1MS_MAX_DEF = 10'd9;
   localparam logic [9:0] CNT_1S_MAX_DEF  = 10'd9;

   function automatic mode_e next_mode(input mode_e cur);
      mode_e nxt;
      case (cur)
         MODE_OFF:    nxt = MODE_BREATH;
         MODE_BREATH: nxt = MODE_CHASE;
         MODE_CHASE:  nxt = MODE_ON;
         default:     nxt = MODE_OFF;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/breath_led_ctrl_if.sv
// Key/LED signal bundle between the debounce source, the sequencer and the board pins.
interface breath_led_ctrl_if #(
   parameter int LED_NUM = 4
);
   logic               key_flag;
   logic [LED_NUM-1:0] led_out;
   logic [1:0]         mode;
   logic               cycle_done;

   modport master (
      output key_flag,
      input  led_out,
      input  mode,
      input  cycle_done
   );

   modport slave (
      input  key_flag,
      output led_out,
      output mode,
      output cycle_done
   );
endinterface

// File: rtl/breath_led_ctrl_timebase.sv
// Tick/slot/step counters driving the breath PWM; produces the breath term and ramp boundaries.
module breath_timebase
   import breath_led_ctrl_pkg::*;
#(
   parameter logic [5:0] CNT_1US_MAX = CNT_1US_MAX_DEF,
   parameter logic [9:0] CNT_1MS_MAX = CNT_1MS_MAX_DEF,
   parameter logic [9:0] CNT_1S_MAX  = CNT_1S_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic brt,
   output logic s_end,
   output logic dir
);

   logic [5:0] cnt_us;
   logic [9:0] cnt_ms;
   logic [9:0] cnt_s;
   logic       us_end;
   logic       ms_end;

   assign us_end = (cnt_us == CNT_1US_MAX);
   assign ms_end = us_end && (cnt_ms == CNT_1MS_MAX);
   assign s_end  = ms_end && (cnt_s == CNT_1S_MAX);

   // Duty grows with cnt_s on the rising ramp and shrinks on the falling ramp
   assign brt = dir ? (cnt_s <= cnt_ms) : (cnt_s >= cnt_ms);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_us <= '0;
         cnt_ms <= '0;
         cnt_s  <= '0;
         dir    <= 1'b0;
      end else if (clear) begin
         cnt_us <= '0;
         cnt_ms <= '0;
         cnt_s  <= '0;
         dir    <= 1'b0;
      end else begin
         cnt_us <= us_end ? 6'd0 : cnt_us + 6'd1;
         if (us_end) begin
            cnt_ms <= ms_end ? 10'd0 : cnt_ms + 10'd1;
         end
         if (ms_end) begin
            cnt_s <= s_end ? 10'd0 : cnt_s + 10'd1;
         end
         if (s_end) begin
            dir <= ~dir;
         end
      end
   end

endmodule

// File: rtl/breath_led_ctrl.sv
// Breathing LED mode sequencer: key-stepped mode FSM, chase channel index and registered LED mux.
module breath_led_ctrl
   import breath_led_ctrl_pkg::*;
#(
   parameter logic [5:0] CNT_1US_MAX = CNT_1US_MAX_DEF,
   parameter logic [9:0] CNT_1MS_MAX = CNT_1MS_MAX_DEF,
   parameter logic [9:0] CNT_1S_MAX  = CNT_1S_MAX_DEF,
   parameter int         LED_NUM     = 4
) (
   input logic             sys_clk,
   input logic             sys_rst_n,
   breath_led_ctrl_if.slave bus
);

   localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_NUM - 1);

   mode_e              state;
   mode_e              state_next;
   logic [IDX_W-1:0]   idx;
   logic [LED_NUM-1:0] led_next;
   logic               brt;
   logic               s_end;
   logic               dir;
   logic               ramp_end;

   // A key press restarts the breath from the bottom of the rising ramp
   breath_timebase #(
      .CNT_1US_MAX (CNT_1US_MAX),
      .CNT_1MS_MAX (CNT_1MS_MAX),
      .CNT_1S_MAX  (CNT_1S_MAX)
   ) u_timebase (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .clear (bus.key_flag),
      .brt   (brt),
      .s_end (s_end),
      .dir   (dir)
   );

   assign ramp_end = s_end && dir;
   assign bus.mode = state;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= MODE_OFF;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.key_flag) begin
         state_next = next_mode(state);
      end
   end

   // The key wins over a coincident ramp end so a mode change never advances the chase
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idx <= '0;
      end else if (bus.key_flag) begin
         idx <= '0;
      end else if (ramp_end) begin
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   always_comb begin
      led_next = '1;
      case (state)
         MODE_ON:     led_next = '0;
         MODE_BREATH: if (brt) led_next = '0;
         MODE_CHASE:  if (brt) led_next[idx] = 1'b0;
         default:     led_next = '1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bus.led_out    <= '1;
         bus.cycle_done <= 1'b0;
      end else begin
         bus.led_out    <= led_next;
         bus.cycle_done <= ramp_end && !bus.key_flag &&
                           ((state == MODE_BREATH) || (state == MODE_CHASE));
      end
   end

endmodule

// File: tb/tb_breath_led_ctrl.sv
// Scoreboard bench for breath_led_ctrl: a time-since-clear model predicts every output cycle.
module tb_breath_led_ctrl;
   import breath_led_ctrl_pkg::*;

   localparam int LED_NUM = 4;
   localparam int US      = 5;
   localparam int MS      = 10;
   localparam int SS      = 10;
   localparam int RAMP    = US * MS * SS;
   localparam int CYCLE   = 2 * RAMP;

   typedef struct packed {
      logic [3:0] led;
      logic [1:0] mode;
      logic       cd;
   } exp_t;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   exp_t expQ[$];
   exp_t mexp;
   exp_t sexp;
   int   checks   = 0;
   int   errors   = 0;
   int   m_t      = 0;
   logic [1:0] m_mode = 2'd0;
   bit   keyEdge  = 1'b0;
   bit   gapValid = 1'b0;
   int   cyc      = 0;
   int   lastCd   = 0;

   breath_led_ctrl_if #(.LED_NUM(LED_NUM)) bus ();

   breath_led_ctrl #(
      .CNT_1US_MAX (6'd4),
      .CNT_1MS_MAX (10'd9),
      .CNT_1S_MAX  (10'd9),
      .LED_NUM     (LED_NUM)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic key);
      bus.key_flag = key;
      @(negedge sys_clk);
   endtask

   // Expected LED pattern from the count of clocks since the last clear
   function automatic logic [3:0] modelLed(input logic [1:0] md, input int t);
      int u, s, ms, ch;
      logic b;
      logic [3:0] r;
      u  = t % CYCLE;
      s  = (u % RAMP) / (US * MS);
      ms = (u % (US * MS)) / US;
      b  = (u < RAMP) ? (s >= ms) : (s <= ms);
      ch = (t / CYCLE) % LED_NUM;
      r  = 4'hF;
      case (md)
         2'd0:    r = 4'hF;
         2'd3:    r = 4'h0;
         2'd1:    r = b ? 4'h0 : 4'hF;
         default: if (b) r[ch] = 1'b0;
      endcase
      return r;
   endfunction

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_t      = 0;
         m_mode   = 2'd0;
         keyEdge  = 1'b0;
         gapValid = 1'b0;
         expQ.delete();
      end else begin
         mexp.led  = modelLed(m_mode, m_t);
         mexp.cd   = !bus.key_flag && (m_mode == 2'd1 || m_mode == 2'd2) && (m_t % CYCLE == CYCLE - 1);
         mexp.mode = bus.key_flag ? m_mode + 2'd1 : m_mode;
         expQ.push_back(mexp);
         if (bus.key_flag) keyEdge = 1'b1;
         m_t    = bus.key_flag ? 0 : m_t + 1;
         m_mode = mexp.mode;
      end
   end

   always @(negedge sys_clk) begin
      if (sys_rst_n && expQ.size() > 0) begin
         sexp = expQ.pop_front();
         checkOutput("led_out", 32'(bus.led_out), 32'(sexp.led));
         checkOutput("mode", 32'(bus.mode), 32'(sexp.mode));
         checkOutput("cycle_done", 32'(bus.cycle_done), 32'(sexp.cd));
         cyc++;
         if (keyEdge) begin
            gapValid = 1'b0;
            keyEdge  = 1'b0;
         end
         if (bus.cycle_done) begin
            if (gapValid) checkOutput("cd_gap", 32'(cyc - lastCd), 32'(CYCLE));
            lastCd   = cyc;
            gapValid = 1'b1;
         end
      end
   end

   initial begin
      int n;
      bus.key_flag = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkOutput("rst_led", 32'(bus.led_out), 32'hF);
      checkOutput("rst_mode", 32'(bus.mode), 32'h0);
      checkOutput("rst_cd", 32'(bus.cycle_done), 32'h0);
      sys_rst_n = 1'b1;

      repeat (2000) applyStimulus(1'b0);
      applyStimulus(1'b1);
      repeat (2500) applyStimulus(1'b0);
      applyStimulus(1'b1);
      repeat (4500) applyStimulus(1'b0);

      // Land the key on the very edge that ends a dimming ramp in CHASE
      n = 0;
      while ((m_t % CYCLE) != CYCLE - 1 && n < 3000) begin
         applyStimulus(1'b0);
         n++;
      end
      checkOutput("align_budget", 32'(n < 3000), 32'h1);
      applyStimulus(1'b1);
      checkOutput("coinc_mode", 32'(bus.mode), 32'h3);
      checkOutput("coinc_cd", 32'(bus.cycle_done), 32'h0);
      applyStimulus(1'b0);
      checkOutput("coinc_led", 32'(bus.led_out), 32'h0);
      repeat (20) applyStimulus(1'b0);
      applyStimulus(1'b1);
      checkOutput("wrap_mode", 32'(bus.mode), 32'h0);
      repeat (20) applyStimulus(1'b0);

      applyStimulus(1'b1);
      applyStimulus(1'b1);
      repeat (2250) applyStimulus(1'b0);

      @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      checkOutput("arst_led", 32'(bus.led_out), 32'hF);
      checkOutput("arst_mode", 32'(bus.mode), 32'h0);
      checkOutput("arst_cd", 32'(bus.cycle_done), 32'h0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (3) applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      repeat (1100) applyStimulus(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
